// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX stage: ALU opcodes, register-file geometry and
// the registered EX-side instruction record.
package id_ex_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0,
    ALU_SUB = 5'd1,
    ALU_AND = 5'd2,
    ALU_OR  = 5'd3,
    ALU_SLL = 5'd4,
    ALU_SRA = 5'd5
  } alu_op_e;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic              is_load;
    logic [REG_W-1:0]  rd;
    logic [4:0]        alu_op;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] store;
  } ex_reg_t;

  // r0 is hardwired, so a producer targeting it never satisfies a consumer.
  function automatic logic reg_hit(input logic [REG_W-1:0] prod,
                                   input logic [REG_W-1:0] cons);
    return (prod != REG_ZERO) && (prod == cons);
  endfunction

  function automatic ex_reg_t ex_bubble();
    ex_reg_t b;
    b        = '0;
    b.alu_op = ALU_ADD;
    return b;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side, forwarding-network and ALU-side signals of the ID/EX stage.
// slave is the stage itself; master is whoever drives decode and observes EX.
interface id_ex_stage_if #(
  parameter int IMM_W = 17,
  parameter int CNT_W = 16
);
  // decode side
  logic              id_valid;
  logic [4:0]        id_alu_op;
  logic [4:0]        id_shamt;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;
  logic [31:0]       id_rs_data;
  logic [31:0]       id_rt_data;
  logic [IMM_W-1:0]  id_imm;
  logic              id_use_imm;
  logic              id_uses_rt;
  logic              id_we;
  logic              id_is_load;
  // forwarding network
  logic [31:0]       ex_fwd_data;
  logic              mem_fwd_we;
  logic [4:0]        mem_fwd_rd;
  logic [31:0]       mem_fwd_data;
  logic              wb_we;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;
  // pipeline control
  logic              flush;
  logic              ex_hold;
  logic              stall_out;
  // EX side
  logic [31:0]       data_operandA;
  logic [31:0]       data_operandB;
  logic [4:0]        ctrl_ALUopcode;
  logic [4:0]        ctrl_shiftamt;
  logic [31:0]       ex_store_data;
  logic              ex_valid;
  logic              ex_we;
  logic              ex_is_load;
  logic [4:0]        ex_rd;
  logic [CNT_W-1:0]  bubble_count;

  modport slave (
    input  id_valid, id_alu_op, id_shamt, id_rs, id_rt, id_rd,
           id_rs_data, id_rt_data, id_imm, id_use_imm, id_uses_rt,
           id_we, id_is_load,
           ex_fwd_data, mem_fwd_we, mem_fwd_rd, mem_fwd_data,
           wb_we, wb_rd, wb_data,
           flush, ex_hold,
    output stall_out,
           data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt,
           ex_store_data, ex_valid, ex_we, ex_is_load, ex_rd, bubble_count
  );

  modport master (
    output id_valid, id_alu_op, id_shamt, id_rs, id_rt, id_rd,
           id_rs_data, id_rt_data, id_imm, id_use_imm, id_uses_rt,
           id_we, id_is_load,
           ex_fwd_data, mem_fwd_we, mem_fwd_rd, mem_fwd_data,
           wb_we, wb_rd, wb_data,
           flush, ex_hold,
    input  stall_out,
           data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt,
           ex_store_data, ex_valid, ex_we, ex_is_load, ex_rd, bubble_count
  );

endinterface

// File: rtl/id_ex_stage_fwd_select.sv
// Per-operand forwarding mux: EX > MEM > WB > register file, r0 reads zero.
// Purely combinational, no backpressure.
module fwd_select
  import id_ex_stage_pkg::*;
(
  input  logic [REG_W-1:0]  src_reg,
  input  logic              fwd_en,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_vld,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              mem_we,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] src_data
);

  always_comb begin
    src_data = rf_data;
    if (src_reg == REG_ZERO) begin
      src_data = '0;
    end else if (fwd_en) begin
      if (ex_vld && reg_hit(ex_rd, src_reg)) begin
        src_data = ex_data;
      end else if (mem_we && reg_hit(mem_rd, src_reg)) begin
        src_data = mem_data;
      end else if (wb_we && reg_hit(wb_rd, src_reg)) begin
        src_data = wb_data;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register with capture-time forwarding and load-use bubble insertion; 1-cycle latency.
// flush > ex_hold (freeze) > load-use (bubble) > capture; stall_out is combinational.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int IMM_W = 17,
  parameter int CNT_W = 16
) (
  input  logic          clock,
  input  logic          reset,
  id_ex_stage_if.slave  bus
);

  ex_reg_t           ex_q;
  ex_reg_t           ex_d;
  ex_reg_t           ex_capture;
  logic [CNT_W-1:0]  bubble_count_q;
  logic [CNT_W-1:0]  bubble_count_d;

  logic              luse;
  logic              ex_fwd_vld;
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;
  logic [DATA_W-1:0] imm_ext;

  // A load in EX has no result yet; it is picked up from MEM after the bubble.
  assign ex_fwd_vld = ex_q.valid & ex_q.we & ~ex_q.is_load;

  assign luse = bus.id_valid & ex_q.valid & ex_q.is_load &
                (reg_hit(ex_q.rd, bus.id_rs) |
                 (bus.id_uses_rt & reg_hit(ex_q.rd, bus.id_rt)));

  assign bus.stall_out = ~reset & (luse | bus.ex_hold);

  assign imm_ext = {{(DATA_W-IMM_W){bus.id_imm[IMM_W-1]}}, bus.id_imm};

  fwd_select u_fwd_rs (
    .src_reg  (bus.id_rs),
    .fwd_en   (1'b1),
    .rf_data  (bus.id_rs_data),
    .ex_vld   (ex_fwd_vld),
    .ex_rd    (ex_q.rd),
    .ex_data  (bus.ex_fwd_data),
    .mem_we   (bus.mem_fwd_we),
    .mem_rd   (bus.mem_fwd_rd),
    .mem_data (bus.mem_fwd_data),
    .wb_we    (bus.wb_we),
    .wb_rd    (bus.wb_rd),
    .wb_data  (bus.wb_data),
    .src_data (rs_fwd)
  );

  fwd_select u_fwd_rt (
    .src_reg  (bus.id_rt),
    .fwd_en   (bus.id_uses_rt),
    .rf_data  (bus.id_rt_data),
    .ex_vld   (ex_fwd_vld),
    .ex_rd    (ex_q.rd),
    .ex_data  (bus.ex_fwd_data),
    .mem_we   (bus.mem_fwd_we),
    .mem_rd   (bus.mem_fwd_rd),
    .mem_data (bus.mem_fwd_data),
    .wb_we    (bus.wb_we),
    .wb_rd    (bus.wb_rd),
    .wb_data  (bus.wb_data),
    .src_data (rt_fwd)
  );

  always_comb begin
    ex_capture = ex_bubble();
    if (bus.id_valid) begin
      ex_capture.valid   = 1'b1;
      ex_capture.we      = bus.id_we;
      ex_capture.is_load = bus.id_is_load;
      ex_capture.rd      = bus.id_rd;
      ex_capture.alu_op  = bus.id_alu_op;
      ex_capture.shamt   = bus.id_shamt;
      ex_capture.op_a    = rs_fwd;
      ex_capture.op_b    = bus.id_use_imm ? imm_ext : rt_fwd;
      ex_capture.store   = rt_fwd;
    end
  end

  always_comb begin
    ex_d           = ex_q;
    bubble_count_d = bubble_count_q;
    if (bus.flush) begin
      ex_d = ex_bubble();
    end else if (!bus.ex_hold) begin
      if (luse) begin
        ex_d = ex_bubble();
        if (bubble_count_q != '1) begin
          bubble_count_d = bubble_count_q + CNT_W'(1);
        end
      end else begin
        ex_d = ex_capture;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_q           <= '0;
      bubble_count_q <= '0;
    end else begin
      ex_q           <= ex_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bus.data_operandA  = ex_q.op_a;
  assign bus.data_operandB  = ex_q.op_b;
  assign bus.ctrl_ALUopcode = ex_q.alu_op;
  assign bus.ctrl_shiftamt  = ex_q.shamt;
  assign bus.ex_store_data  = ex_q.store;
  assign bus.ex_valid       = ex_q.valid;
  assign bus.ex_we          = ex_q.we;
  assign bus.ex_is_load     = ex_q.is_load;
  assign bus.ex_rd          = ex_q.rd;
  assign bus.bubble_count   = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic against a
// behavioural model of the forwarding / hazard / flush / hold rules.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int IMM_W = 17;
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int tests_run = 0;
  int tests_failed = 0;

  id_ex_stage_if #(.IMM_W(IMM_W), .CNT_W(CNT_W)) bus ();
  id_ex_stage #(.IMM_W(IMM_W), .CNT_W(CNT_W)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  typedef struct packed {
    logic             stall;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [4:0]       op;
    logic [4:0]       sh;
    logic [31:0]      st;
    logic             v;
    logic             we;
    logic             ld;
    logic [4:0]       rd;
    logic [CNT_W-1:0] cnt;
  } out_t;

  out_t m;  // model of what EX should hold

  function automatic out_t get_outs();
    out_t o;
    o.stall = bus.stall_out;      o.a  = bus.data_operandA;
    o.b     = bus.data_operandB;  o.op = bus.ctrl_ALUopcode;
    o.sh    = bus.ctrl_shiftamt;  o.st = bus.ex_store_data;
    o.v     = bus.ex_valid;       o.we = bus.ex_we;
    o.ld    = bus.ex_is_load;     o.rd = bus.ex_rd;
    o.cnt   = bus.bubble_count;
    return o;
  endfunction

  function automatic out_t exp_out(input logic [31:0] a, b, st, input logic [4:0] op, sh, rd,
                                   input logic v, we, ld, input logic [CNT_W-1:0] cnt,
                                   input logic stall);
    out_t e;
    e.a = a; e.b = b; e.st = st; e.op = op; e.sh = sh; e.rd = rd;
    e.v = v; e.we = we; e.ld = ld; e.cnt = cnt; e.stall = stall;
    return e;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic model_luse();
    if (!bus.id_valid || !m.v || !m.ld || m.rd == 5'd0) return 1'b0;
    return (m.rd == bus.id_rs) || (bus.id_uses_rt && m.rd == bus.id_rt);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] r, input logic [31:0] rf,
                                             input logic fwd);
    logic        en  [3];
    logic [4:0]  rd  [3];
    logic [31:0] dat [3];
    if (r == 5'd0) return 32'd0;
    if (!fwd) return rf;
    en[0] = m.v && m.we && !m.ld; rd[0] = m.rd;       dat[0] = bus.ex_fwd_data;
    en[1] = bus.mem_fwd_we;       rd[1] = bus.mem_fwd_rd; dat[1] = bus.mem_fwd_data;
    en[2] = bus.wb_we;            rd[2] = bus.wb_rd;  dat[2] = bus.wb_data;
    for (int k = 0; k < 3; k++)
      if (en[k] && rd[k] == r) return dat[k];
    return rf;
  endfunction

  function automatic out_t model_next();
    out_t n;
    logic [31:0] rtv;
    n = m;
    if (bus.flush) begin
      n = '0; n.cnt = m.cnt;
    end else if (bus.ex_hold) begin
      n = m;
    end else if (model_luse()) begin
      n = '0; n.cnt = (m.cnt == CNT_MAX) ? m.cnt : m.cnt + CNT_W'(1);
    end else if (!bus.id_valid) begin
      n = '0; n.cnt = m.cnt;
    end else begin
      rtv  = model_read(bus.id_rt, bus.id_rt_data, bus.id_uses_rt);
      n.v  = 1'b1;           n.we = bus.id_we;   n.ld = bus.id_is_load;
      n.rd = bus.id_rd;      n.op = bus.id_alu_op; n.sh = bus.id_shamt;
      n.a  = model_read(bus.id_rs, bus.id_rs_data, 1'b1);
      n.b  = bus.id_use_imm ? 32'(signed'(bus.id_imm)) : rtv;
      n.st = rtv;
    end
    n.stall = 1'b0;
    return n;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_inputs();
    bus.id_valid = 0; bus.id_alu_op = 0; bus.id_shamt = 0; bus.id_rs = 0; bus.id_rt = 0;
    bus.id_rd = 0; bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0;
    bus.id_use_imm = 0; bus.id_uses_rt = 0; bus.id_we = 0; bus.id_is_load = 0;
    bus.ex_fwd_data = 0; bus.mem_fwd_we = 0; bus.mem_fwd_rd = 0; bus.mem_fwd_data = 0;
    bus.wb_we = 0; bus.wb_rd = 0; bus.wb_data = 0; bus.flush = 0; bus.ex_hold = 0;
  endtask

  task automatic set_instr(input logic [4:0] op, rs, rt, rd, input logic [31:0] rs_d, rt_d,
                           input logic uses_rt, we, ld);
    bus.id_valid = 1; bus.id_alu_op = op; bus.id_shamt = 0; bus.id_rs = rs; bus.id_rt = rt;
    bus.id_rd = rd; bus.id_rs_data = rs_d; bus.id_rt_data = rt_d; bus.id_imm = 0;
    bus.id_use_imm = 0; bus.id_uses_rt = uses_rt; bus.id_we = we; bus.id_is_load = ld;
  endtask

  task automatic cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    #1 reset = 1'b0;
    @(negedge clock);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    out_t o;
    clear_inputs();
    @(negedge clock);
    o = get_outs();
    tests_run++;
    if (o !== out_t'(0)) begin
      tests_failed++; $display("FAIL reset_state: got %h want %h", o, out_t'(0));
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_capture();
    out_t o, e;
    do_reset();
    set_instr(ALU_ADD, 1, 2, 3, 32'd5, 32'd7, 1, 1, 0);
    cycle();
    o = get_outs(); e = exp_out(5, 7, 7, ALU_ADD, 0, 3, 1, 1, 0, 0, 0);
    tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL capture_add: got %h want %h", o, e); end
    set_instr(ALU_SLL, 3, 0, 6, 32'h100, 32'h0, 0, 1, 0);
    bus.id_shamt = 5'd7; bus.ex_fwd_data = 32'hC;
    cycle();
    o = get_outs(); e = exp_out(32'hC, 0, 0, ALU_SLL, 7, 6, 1, 1, 0, 0, 0);
    tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL capture_sll_exfwd: got %h want %h", o, e); end
  endtask

  task automatic test_fwd_priority();
    out_t o, e;
    do_reset();
    set_instr(ALU_ADD, 0, 0, 1, 0, 0, 0, 1, 0);
    cycle();
    set_instr(ALU_OR, 1, 1, 1, 32'hAA, 32'hBB, 1, 0, 0);
    bus.ex_fwd_data = 32'h11;
    bus.mem_fwd_we = 1; bus.mem_fwd_rd = 1; bus.mem_fwd_data = 32'h22;
    bus.wb_we = 1; bus.wb_rd = 1; bus.wb_data = 32'h33;
    cycle();
    o = get_outs(); e = exp_out(32'h11, 32'h11, 32'h11, ALU_OR, 0, 1, 1, 0, 0, 0, 0);
    tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL fwd_ex_wins: got %h want %h", o, e); end
    set_instr(ALU_AND, 1, 1, 0, 32'hAA, 32'hBB, 1, 1, 0);
    cycle();
    o = get_outs(); e = exp_out(32'h22, 32'h22, 32'h22, ALU_AND, 0, 0, 1, 1, 0, 0, 0);
    tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL fwd_mem_wins: got %h want %h", o, e); end
    set_instr(ALU_ADD, 0, 0, 2, 32'h55, 32'h66, 1, 1, 0);
    bus.mem_fwd_rd = 0; bus.wb_rd = 0;
    cycle();
    o = get_outs(); e = exp_out(0, 0, 0, ALU_ADD, 0, 2, 1, 1, 0, 0, 0);
    tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL fwd_r0_zero: got %h want %h", o, e); end
    set_instr(ALU_SUB, 1, 2, 4, 32'hAA, 32'hBB, 0, 1, 0);
    bus.mem_fwd_we = 0; bus.wb_rd = 1;
    cycle();
    o = get_outs(); e = exp_out(32'h33, 32'hBB, 32'hBB, ALU_SUB, 0, 4, 1, 1, 0, 0, 0);
    tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL fwd_wb_and_rt_unused: got %h want %h", o, e); end
    set_instr(ALU_ADD, 3, 4, 5, 32'h77, 32'hBB, 1, 1, 0);
    bus.ex_fwd_data = 32'h44; bus.wb_we = 0;
    cycle();
    o = get_outs(); e = exp_out(32'h77, 32'h44, 32'h44, ALU_ADD, 0, 5, 1, 1, 0, 0, 0);
    tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL fwd_rt_from_ex: got %h want %h", o, e); end
  endtask

  task automatic test_load_use();
    out_t o, e;
    do_reset();
    set_instr(ALU_ADD, 2, 0, 4, 32'h100, 0, 0, 1, 1);
    cycle();
    o = get_outs(); e = exp_out(32'h100, 0, 0, ALU_ADD, 0, 4, 1, 1, 1, 0, 0);
    tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL lu_load_captured: got %h want %h", o, e); end
    set_instr(ALU_SUB, 4, 1, 5, 32'hDEAD, 32'h3, 1, 1, 0);
    #1;
    tests_run++;
    if (bus.stall_out !== 1'b1) begin
      tests_failed++; $display("FAIL lu_stall: got %b want 1", bus.stall_out);
    end
    cycle();
    o = get_outs(); e = exp_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL lu_bubble: got %h want %h", o, e); end
    bus.mem_fwd_we = 1; bus.mem_fwd_rd = 4; bus.mem_fwd_data = 32'h99;
    cycle();
    o = get_outs(); e = exp_out(32'h99, 3, 3, ALU_SUB, 0, 5, 1, 1, 0, 1, 0);
    tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL lu_mem_fwd: got %h want %h", o, e); end
    set_instr(ALU_ADD, 0, 0, 6, 0, 0, 0, 1, 1);
    bus.mem_fwd_we = 0;
    cycle();
    set_instr(ALU_ADD, 1, 6, 7, 1, 2, 0, 1, 0);
    #1;
    tests_run++;
    if (bus.stall_out !== 1'b0) begin
      tests_failed++; $display("FAIL lu_rt_unused_no_stall: got %b want 0", bus.stall_out);
    end
    bus.id_uses_rt = 1;
    #1;
    tests_run++;
    if (bus.stall_out !== 1'b1) begin
      tests_failed++; $display("FAIL lu_rt_stall: got %b want 1", bus.stall_out);
    end
    bus.id_valid = 0;
    #1;
    tests_run++;
    if (bus.stall_out !== 1'b0) begin
      tests_failed++; $display("FAIL lu_invalid_no_stall: got %b want 0", bus.stall_out);
    end
    cycle();
    o = get_outs(); e = exp_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL invalid_bubble_nocount: got %h want %h", o, e); end
  endtask

  task automatic test_imm();
    out_t o, e;
    do_reset();
    set_instr(ALU_ADD, 0, 2, 8, 0, 32'h1234, 1, 1, 0);
    bus.id_use_imm = 1; bus.id_imm = 17'h1FFFF;
    cycle();
    o = get_outs(); e = exp_out(0, 32'hFFFFFFFF, 32'h1234, ALU_ADD, 0, 8, 1, 1, 0, 0, 0);
    tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL imm_negative: got %h want %h", o, e); end
    bus.id_imm = 17'h0FFFF;
    bus.mem_fwd_we = 1; bus.mem_fwd_rd = 2; bus.mem_fwd_data = 32'h5678;
    cycle();
    o = get_outs(); e = exp_out(0, 32'h0000FFFF, 32'h5678, ALU_ADD, 0, 8, 1, 1, 0, 0, 0);
    tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL imm_pos_store_fwd: got %h want %h", o, e); end
  endtask

  task automatic test_flush_hold();
    out_t o, e;
    do_reset();
    set_instr(ALU_ADD, 0, 0, 4, 0, 0, 0, 1, 1);
    cycle();
    set_instr(ALU_SUB, 4, 0, 5, 32'h1, 32'h2, 0, 1, 0);
    bus.flush = 1;
    #1;
    tests_run++;
    if (bus.stall_out !== 1'b1) begin
      tests_failed++; $display("FAIL flush_lu_stall_before: got %b want 1", bus.stall_out);
    end
    cycle();
    o = get_outs(); e = '0;
    tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL flush_during_luse: got %h want %h", o, e); end
    bus.flush = 0;
    set_instr(ALU_OR, 1, 2, 9, 32'h10, 32'h20, 1, 1, 0);
    cycle();
    e = exp_out(32'h10, 32'h20, 32'h20, ALU_OR, 0, 9, 1, 1, 0, 0, 1);
    bus.ex_hold = 1;
    for (int i = 0; i < 3; i++) begin
      bus.id_rs = 5'($urandom_range(1, 31)); bus.id_rs_data = $urandom;
      bus.id_rd = 5'($urandom); bus.id_alu_op = 5'($urandom_range(5));
      cycle();
      o = get_outs();
      tests_run++;
      if (o !== e) begin tests_failed++; $display("FAIL hold_frozen_%0d: got %h want %h", i, o, e); end
    end
    bus.flush = 1;
    cycle();
    bus.flush = 0; bus.ex_hold = 0; bus.id_valid = 0;
    #1;
    o = get_outs(); e = '0;
    tests_run++;
    if (o !== e) begin tests_failed++; $display("FAIL flush_during_hold: got %h want %h", o, e); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_stall();
    out_t o;
    do_reset();
    set_instr(ALU_ADD, 0, 0, 4, 0, 0, 0, 1, 1); cycle();
    set_instr(ALU_ADD, 4, 0, 5, 0, 0, 0, 1, 0); cycle();
    set_instr(ALU_ADD, 0, 0, 4, 0, 0, 0, 1, 1); cycle();
    set_instr(ALU_ADD, 4, 0, 5, 0, 0, 0, 1, 0);
    #1;
    tests_run++;
    if (bus.stall_out !== 1'b1 || bus.bubble_count !== CNT_W'(1)) begin
      tests_failed++;
      $display("FAIL pre_reset_stall: got stall %b cnt %0d want 1 1", bus.stall_out, bus.bubble_count);
    end
    #1 reset = 1'b1;
    #1;
    o = get_outs();
    tests_run++;
    if (o !== out_t'(0)) begin tests_failed++; $display("FAIL async_reset_mid_stall: got %h want 0", o); end
    reset = 1'b0;
    #1;
    o = get_outs();
    tests_run++;
    if (o !== out_t'(0)) begin tests_failed++; $display("FAIL after_reset_release: got %h want 0", o); end
    clear_inputs();
    @(negedge clock);
  endtask

  task automatic test_saturation();
    logic [CNT_W-1:0] want;
    do_reset();
    for (int i = 1; i <= int'(CNT_MAX) + 4; i++) begin
      set_instr(ALU_ADD, 0, 0, 4, 0, 0, 0, 1, 1); cycle();
      set_instr(ALU_ADD, 4, 0, 5, 0, 0, 0, 1, 0); cycle();
      want = (i > int'(CNT_MAX)) ? CNT_MAX : CNT_W'(i);
      tests_run++;
      if (bus.bubble_count !== want) begin
        tests_failed++; $display("FAIL bubble_sat_%0d: got %0d want %0d", i, bus.bubble_count, want);
      end
    end
  endtask

  task automatic test_random();
    out_t o, e, nxt;
    do_reset();
    m = '0;
    for (int n = 0; n < 2000; n++) begin
      bus.id_valid = ($urandom_range(3) != 0); bus.id_alu_op = 5'($urandom_range(5));
      bus.id_shamt = 5'($urandom);             bus.id_rs = 5'($urandom_range(3));
      bus.id_rt = 5'($urandom_range(3));       bus.id_rd = 5'($urandom_range(3));
      bus.id_rs_data = $urandom;               bus.id_rt_data = $urandom;
      bus.id_imm = IMM_W'($urandom);           bus.id_use_imm = ($urandom_range(3) == 0);
      bus.id_uses_rt = 1'($urandom_range(1));  bus.id_we = ($urandom_range(3) != 0);
      bus.id_is_load = ($urandom_range(2) == 0); bus.ex_fwd_data = $urandom;
      bus.mem_fwd_we = 1'($urandom_range(1));  bus.mem_fwd_rd = 5'($urandom_range(3));
      bus.mem_fwd_data = $urandom;             bus.wb_we = 1'($urandom_range(1));
      bus.wb_rd = 5'($urandom_range(3));       bus.wb_data = $urandom;
      bus.flush = ($urandom_range(7) == 0);    bus.ex_hold = ($urandom_range(7) == 0);
      #1;
      tests_run++;
      if (bus.stall_out !== (model_luse() | bus.ex_hold)) begin
        tests_failed++;
        $display("FAIL rand_stall_%0d: got %b want %b", n, bus.stall_out, model_luse() | bus.ex_hold);
      end
      nxt = model_next();
      cycle();
      m = nxt;
      e = m; e.stall = model_luse() | bus.ex_hold;
      o = get_outs();
      tests_run++;
      if (o !== e) begin tests_failed++; $display("FAIL rand_state_%0d: got %h want %h", n, o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_fwd_priority();
    test_load_use();
    test_imm();
    test_flush_hold();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
